// File: rtl/fifo_stim_gen.sv
// Write-side traffic generator: pushes a ramp or Galois-LFSR sequence into a
// buffer write port, honouring full backpressure and a programmable idle gap.
module fifo_stim_gen #(
   parameter int                 DATA_W = 8,
   parameter int                 CNT_W  = 8,
   parameter int                 GAP_W  = 4,
   parameter logic [DATA_W-1:0]  TAPS   = 8'hB8,
   parameter logic [DATA_W-1:0]  SEED   = 8'h5A
) (
   input  logic                     refclk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     mode,
   input  logic [CNT_W-1:0]         num_items,
   input  logic [GAP_W-1:0]         gap,
   input  logic signed [DATA_W-1:0] start_val,
   input  logic                     full,
   output logic                     wr_en,
   output logic signed [DATA_W-1:0] wr_data,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         pushed_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PUSH,
      S_GAP,
      S_DONE
   } state_e;

   localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic [CNT_W-1:0]    pushed_cnt_q, pushed_cnt_d;
   logic [CNT_W-1:0]    num_q, num_d;
   logic [GAP_W-1:0]    gap_q, gap_d;
   logic [GAP_W-1:0]    gcnt_q, gcnt_d;
   logic                mode_q, mode_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                push;
   logic [DATA_W-1:0]   next_val;

   // Abort must suppress the strobe in the very cycle it is seen.
   assign push = (state_q == S_PUSH) && !full && !abort;

   assign next_val = mode_q ? ((wr_data_q >> 1) ^ (wr_data_q[0] ? TAPS : '0))
                            : (wr_data_q + DATA_ONE);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d      = state_q;
      wr_data_d    = wr_data_q;
      pushed_cnt_d = pushed_cnt_q;
      num_d        = num_q;
      gap_d        = gap_q;
      gcnt_d       = gcnt_q;
      mode_d       = mode_q;

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               pushed_cnt_d = '0;
               if (num_items == '0) begin
                  state_d = S_DONE;
               end else begin
                  num_d   = num_items;
                  gap_d   = gap;
                  mode_d  = mode;
                  wr_data_d = (mode && (start_val == '0)) ? SEED : start_val;
                  state_d = S_PUSH;
               end
            end
         end
         S_PUSH: begin
            if (push) begin
               pushed_cnt_d = pushed_cnt_q + CNT_ONE;
               wr_data_d    = next_val;
               if (pushed_cnt_d == num_q) begin
                  state_d = S_DONE;
               end else if (gap_q != '0) begin
                  state_d = S_GAP;
                  gcnt_d  = gap_q;
               end
            end
         end
         S_GAP: begin
            if (gcnt_q == GAP_ONE) state_d = S_PUSH;
            else                   gcnt_d  = gcnt_q - GAP_ONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
   end

   // busy/done are registered from the next state so they line up with it.
   assign busy_d = (state_d == S_PUSH) || (state_d == S_GAP);
   assign done_d = (state_d == S_DONE);

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_data_q    <= '0;
         pushed_cnt_q <= '0;
         num_q        <= '0;
         gap_q        <= '0;
         gcnt_q       <= '0;
         mode_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         wr_data_q    <= wr_data_d;
         pushed_cnt_q <= pushed_cnt_d;
         num_q        <= num_d;
         gap_q        <= gap_d;
         gcnt_q       <= gcnt_d;
         mode_q       <= mode_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign wr_en      = push;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pushed_cnt = pushed_cnt_q;

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Directed bench for fifo_stim_gen: ramp, gap, backpressure, LFSR, reset, abort.
module tb_fifo_stim_gen;

   logic              refclk = 1'b0;
   logic              rst_n;
   logic              start, abort, mode, full;
   logic [7:0]        num_items;
   logic [3:0]        gap;
   logic signed [7:0] start_val;
   logic              wr_en;
   logic signed [7:0] wr_data;
   logic              busy, done;
   logic [7:0]        pushed_cnt;

   int checks   = 0;
   int failures = 0;

   fifo_stim_gen dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .mode       (mode),
      .num_items  (num_items),
      .gap        (gap),
      .start_val  (start_val),
      .full       (full),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .pushed_cnt (pushed_cnt)
   );

   always #5 refclk = ~refclk;

   // Drive inputs on the falling edge, then let outputs settle before sampling.
   task automatic cyc(input logic st, input logic ab, input logic fl);
      @(negedge refclk);
      start = st;
      abort = ab;
      full  = fl;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 0; abort = 0; mode = 0; full = 0;
      num_items = 0; gap = 0; start_val = 0;
      repeat (2) @(negedge refclk);
      #1;
      checks++;
      if ({wr_en, busy, done} !== 3'b000 || wr_data !== 8'sd0 || pushed_cnt !== 8'd0) begin
         failures++;
         $display("FAIL reset got we/busy/done=%b%b%b data=%0d cnt=%0d want all 0",
                  wr_en, busy, done, wr_data, pushed_cnt);
      end
      @(negedge refclk);
      rst_n = 1'b1;
   endtask

   task automatic test_ramp_wrap();
      logic       e_we   [6] = '{1, 1, 1, 1, 0, 0};
      logic [7:0] e_dat  [4] = '{8'h7E, 8'h7F, 8'h80, 8'h81};
      logic       e_done [6] = '{0, 0, 0, 0, 1, 0};
      logic       e_busy [6] = '{1, 1, 1, 1, 0, 0};
      mode = 0; num_items = 4; gap = 0; start_val = 126;
      cyc(1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 0);
         checks++;
         if (wr_en !== e_we[i] || done !== e_done[i] || busy !== e_busy[i]) begin
            failures++;
            $display("FAIL ramp_ctl[%0d] got we/done/busy=%b%b%b want %b%b%b",
                     i, wr_en, done, busy, e_we[i], e_done[i], e_busy[i]);
         end
         if (i < 4) begin
            checks++;
            if (wr_data !== e_dat[i]) begin
               failures++;
               $display("FAIL ramp_data[%0d] got=%h want=%h", i, wr_data, e_dat[i]);
            end
         end
         if (i == 4) begin
            checks++;
            if (pushed_cnt !== 8'd4) begin
               failures++;
               $display("FAIL ramp_cnt got=%0d want=4", pushed_cnt);
            end
         end
      end
   endtask

   task automatic test_gap();
      logic       e_we   [9] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
      logic [7:0] e_dat  [9] = '{0, 1, 1, 1, 2, 2, 2, 3, 3};
      logic       e_done [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
      mode = 0; num_items = 3; gap = 2; start_val = 0;
      cyc(1, 0, 0);
      for (int i = 0; i < 9; i++) begin
         cyc(0, 0, 0);
         checks++;
         if (wr_en !== e_we[i] || done !== e_done[i] || wr_data !== e_dat[i]) begin
            failures++;
            $display("FAIL gap[%0d] got we/done=%b%b data=%0d want %b%b data=%0d",
                     i, wr_en, done, wr_data, e_we[i], e_done[i], e_dat[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic       fl     [11] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      logic       e_we   [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      logic [7:0] e_dat  [11] = '{0, 1, 2, 2, 2, 2, 2, 2, 3, 4, 5};
      logic       e_done [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      mode = 0; num_items = 5; gap = 0; start_val = 0;
      cyc(1, 0, 0);
      for (int i = 0; i < 11; i++) begin
         cyc(0, 0, fl[i]);
         checks++;
         if (wr_en !== e_we[i] || done !== e_done[i] || wr_data !== e_dat[i]) begin
            failures++;
            $display("FAIL full[%0d] got we/done=%b%b data=%0d want %b%b data=%0d",
                     i, wr_en, done, wr_data, e_we[i], e_done[i], e_dat[i]);
         end
      end
      checks++;
      if (pushed_cnt !== 8'd5) begin
         failures++;
         $display("FAIL full_cnt got=%0d want=5", pushed_cnt);
      end
   endtask

   task automatic test_lfsr_and_empty();
      logic [7:0] e_dat [4] = '{8'h5A, 8'h2D, 8'hAE, 8'h57};
      logic       seen_we;
      mode = 1; num_items = 4; gap = 0; start_val = 0;
      cyc(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0);
         checks++;
         if (wr_en !== 1'b1 || wr_data !== e_dat[i]) begin
            failures++;
            $display("FAIL lfsr[%0d] got we=%b data=%h want we=1 data=%h",
                     i, wr_en, wr_data, e_dat[i]);
         end
      end
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      num_items = 0;
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      checks++;
      if (done !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0 || pushed_cnt !== 8'd0) begin
         failures++;
         $display("FAIL empty_done got done/we/busy=%b%b%b cnt=%0d want 100 cnt=0",
                  done, wr_en, busy, pushed_cnt);
      end
      seen_we = wr_en;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0);
         seen_we |= wr_en;
      end
      checks++;
      if (seen_we !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL empty_quiet got we_seen=%b done=%b want 0 0", seen_we, done);
      end
   endtask

   task automatic test_async_reset();
      logic seen;
      mode = 0; num_items = 6; gap = 0; start_val = 10;
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 8'sd11) begin
         failures++;
         $display("FAIL rst_pre got we=%b data=%0d want we=1 data=11", wr_en, wr_data);
      end
      @(negedge refclk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, busy, done} !== 3'b000 || wr_data !== 8'sd0 || pushed_cnt !== 8'd0) begin
         failures++;
         $display("FAIL rst_mid got we/busy/done=%b%b%b data=%0d cnt=%0d want all 0",
                  wr_en, busy, done, wr_data, pushed_cnt);
      end
      @(negedge refclk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0);
         seen |= wr_en | busy;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL rst_idle got activity=%b want 0", seen);
      end
   endtask

   task automatic test_restart_abort();
      mode = 0; num_items = 6; gap = 0; start_val = 20;
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      num_items = 2; start_val = 99;
      cyc(1, 0, 0);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 8'sd21) begin
         failures++;
         $display("FAIL busy_start got we=%b data=%0d want we=1 data=21", wr_en, wr_data);
      end
      cyc(0, 0, 0);
      checks++;
      if (wr_en !== 1'b1 || wr_data !== 8'sd22) begin
         failures++;
         $display("FAIL busy_ignore got we=%b data=%0d want we=1 data=22", wr_en, wr_data);
      end
      cyc(0, 1, 0);
      checks++;
      if (wr_en !== 1'b0 || wr_data !== 8'sd23) begin
         failures++;
         $display("FAIL abort_mask got we=%b data=%0d want we=0 data=23", wr_en, wr_data);
      end
      cyc(0, 0, 0);
      checks++;
      if ({wr_en, busy, done} !== 3'b000 || pushed_cnt !== 8'd3) begin
         failures++;
         $display("FAIL abort_idle got we/busy/done=%b%b%b cnt=%0d want 000 cnt=3",
                  wr_en, busy, done, pushed_cnt);
      end
      cyc(0, 0, 0);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL abort_nodone got done=%b want 0", done);
      end
      num_items = 4; start_val = 50;
      cyc(1, 1, 0);
      cyc(0, 0, 0);
      checks++;
      if ({wr_en, busy, done} !== 3'b000 || pushed_cnt !== 8'd3) begin
         failures++;
         $display("FAIL abort_start got we/busy/done=%b%b%b cnt=%0d want 000 cnt=3",
                  wr_en, busy, done, pushed_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_wrap();
      test_gap();
      test_backpressure();
      test_lfsr_and_empty();
      test_async_reset();
      test_restart_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
